// File: rtl/muskbus_line_reader_if.sv
// Signal bundle between the line reader, its fetch client and the Muskbus.
// The master modport is the reader's view; the slave modport is the client/memory side.
interface muskbus_line_reader_if #(
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned BUS_W      = 64,
    parameter int unsigned TAG_W      = 13
);
    logic                      reqcyc;
    logic [63:0]               addr;
    logic                      respcyc;
    logic [0:LINE_BYTES*8-1]   data;
    logic                      bus_reqcyc;
    logic [BUS_W-1:0]          bus_req;
    logic [TAG_W-1:0]          bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_W-1:0]          bus_resp;
    logic [TAG_W-1:0]          bus_resptag;
    logic                      bus_respack;

    modport master (
        input  reqcyc, addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output respcyc, data, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport slave (
        output reqcyc, addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  respcyc, data, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/muskbus_line_reader.sv
// Fetches one line-aligned block over Muskbus and returns it as one wide word with a valid pulse.
// Optional MUSKBUS_READER_TAGCHK_EN: accept response beats only when the tag matches the issued tag.
module muskbus_line_reader #(
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned BUS_W      = 64,
    parameter int unsigned TAG_W      = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    muskbus_line_reader_if.master mb
);
    localparam int unsigned LINE_W     = LINE_BYTES * 8;
    localparam int unsigned BEATS      = LINE_W / BUS_W;
    localparam int unsigned BEAT_BYTES = BUS_W / 8;
    localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [63:0] ALIGN_MASK = ~64'(LINE_BYTES - 1);
    // READ opcode, MEMORY target, zero sequence field
    localparam logic [TAG_W-1:0] READ_MEM_TAG = TAG_W'(13'h1100);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t              r_state;
    logic [BUS_W-1:0]    r_addr;
    logic [TAG_W-1:0]    r_tag;
    logic [CNT_W-1:0]    r_cnt;
    logic [0:LINE_W-1]   r_buf;
    logic [0:LINE_W-1]   r_data;
    logic                r_respcyc;
    logic                r_bus_reqcyc;

    state_t              w_state_nxt;
    logic [BUS_W-1:0]    w_addr_nxt;
    logic [TAG_W-1:0]    w_tag_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [0:LINE_W-1]   w_buf_nxt;
    logic [0:LINE_W-1]   w_data_nxt;
    logic                w_respcyc_nxt;
    logic                w_bus_reqcyc_nxt;
    logic                w_beat;
    logic                w_respack_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_tag        <= '0;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_data       <= '0;
            r_respcyc    <= 1'b0;
            r_bus_reqcyc <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_tag        <= w_tag_nxt;
            r_cnt        <= w_cnt_nxt;
            r_buf        <= w_buf_nxt;
            r_data       <= w_data_nxt;
            r_respcyc    <= w_respcyc_nxt;
            r_bus_reqcyc <= w_bus_reqcyc_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_tag_nxt        = r_tag;
        w_cnt_nxt        = r_cnt;
        w_buf_nxt        = r_buf;
        w_data_nxt       = r_data;
        w_respcyc_nxt    = 1'b0;
        w_bus_reqcyc_nxt = 1'b0;
        w_beat           = 1'b0;
        w_respack_c      = 1'b0;

        case (r_state)
            IDLE: begin
                if (mb.reqcyc) begin
                    w_addr_nxt       = BUS_W'(mb.addr & ALIGN_MASK);
                    w_tag_nxt        = READ_MEM_TAG;
                    w_bus_reqcyc_nxt = 1'b1;
                    w_state_nxt      = REQ;
                end
            end
            REQ: begin
                w_bus_reqcyc_nxt = 1'b1;
                if (mb.bus_reqack) begin
                    w_bus_reqcyc_nxt = 1'b0;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = RESP;
                end
            end
            RESP: begin
`ifdef MUSKBUS_READER_TAGCHK_EN
                w_beat = mb.bus_respcyc && (mb.bus_resptag == r_tag);
`else
                w_beat = mb.bus_respcyc;
`endif
                w_respack_c = w_beat;
                if (w_beat) begin
                    // beat b, byte j lands in line byte b*BEAT_BYTES + j
                    for (int b = 0; b < int'(BEATS); b++) begin
                        if (r_cnt == CNT_W'(b)) begin
                            for (int j = 0; j < int'(BEAT_BYTES); j++) begin
                                w_buf_nxt[(b*int'(BEAT_BYTES) + j)*8 +: 8] = mb.bus_resp[j*8 +: 8];
                            end
                        end
                    end
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BEATS - 1)) begin
                        w_cnt_nxt     = '0;
                        w_data_nxt    = w_buf_nxt;
                        w_respcyc_nxt = 1'b1;
                        w_state_nxt   = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mb.respcyc     = r_respcyc;
    assign mb.data        = r_data;
    assign mb.bus_reqcyc  = r_bus_reqcyc;
    assign mb.bus_req     = r_addr;
    assign mb.bus_reqtag  = r_tag;
    assign mb.bus_respack = w_respack_c;
endmodule

// File: tb/tb_muskbus_line_reader.sv
// Directed bench for muskbus_line_reader: reset, stalled request, back-to-back and gapped bursts,
// turnaround, mid-burst reset, and tag filtering when MUSKBUS_READER_TAGCHK_EN is defined.
module tb_muskbus_line_reader;
    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned BUS_W      = 64;
    localparam int unsigned TAG_W      = 13;
    localparam int unsigned CW         = 512;

    logic clk = 1'b0;
    logic reset;

    muskbus_line_reader_if #(.LINE_BYTES(LINE_BYTES), .BUS_W(BUS_W), .TAG_W(TAG_W)) mb ();

    muskbus_line_reader #(.LINE_BYTES(LINE_BYTES), .BUS_W(BUS_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .mb    (mb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [0:511] exp_line;
    logic [0:511] inv_line;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_word(input int i, input logic inv);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(i*8 + j) ^ {8{inv}};
        return w;
    endfunction

    initial begin
        reset          = 1'b0;
        mb.reqcyc      = 1'b0;
        mb.addr        = '0;
        mb.bus_reqack  = 1'b0;
        mb.bus_respcyc = 1'b0;
        mb.bus_resp    = '0;
        mb.bus_resptag = '0;
        for (int k = 0; k < 64; k++) exp_line[k*8 +: 8] = 8'(k);
        inv_line = ~exp_line;

        // reset held for two edges
        tick(); tick(); #1;
        chk("rst_respcyc",    CW'(mb.respcyc),     CW'(0));
        chk("rst_bus_reqcyc", CW'(mb.bus_reqcyc),  CW'(0));
        chk("rst_respack",    CW'(mb.bus_respack), CW'(0));
        chk("rst_data",       CW'(mb.data),        CW'(0));

        // request with unaligned address, stalled for three cycles
        reset = 1'b1; mb.reqcyc = 1'b1; mb.addr = 64'h1000_0037;
        tick(); #1;
        chk("req_valid", CW'(mb.bus_reqcyc), CW'(1));
        chk("req_addr",  CW'(mb.bus_req),    CW'(64'h1000_0000));
        chk("req_tag",   CW'(mb.bus_reqtag), CW'(13'h1100));
        mb.reqcyc = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            chk("req_hold_valid", CW'(mb.bus_reqcyc), CW'(1));
            chk("req_hold_addr",  CW'(mb.bus_req),    CW'(64'h1000_0000));
            chk("req_hold_tag",   CW'(mb.bus_reqtag), CW'(13'h1100));
        end
        mb.bus_reqack = 1'b1;
        tick(); mb.bus_reqack = 1'b0; #1;
        chk("req_drop", CW'(mb.bus_reqcyc), CW'(0));

        // eight back-to-back beats
        for (int i = 0; i < 8; i++) begin
            mb.bus_respcyc = 1'b1; mb.bus_resp = beat_word(i, 1'b0); mb.bus_resptag = 13'h1100; #1;
            chk("b2b_ack", CW'(mb.bus_respack), CW'(1));
            if (i == 7) chk("b2b_early", CW'(mb.respcyc), CW'(0));
            tick();
        end
        mb.bus_respcyc = 1'b0; #1;
        chk("b2b_respcyc", CW'(mb.respcyc), CW'(1));
        chk("b2b_data",    CW'(mb.data),    CW'(exp_line));
        chk("b2b_byte0",   CW'(mb.data[0*8 +: 8]),  CW'(8'h00));
        chk("b2b_byte9",   CW'(mb.data[9*8 +: 8]),  CW'(8'h09));
        chk("b2b_byte63",  CW'(mb.data[63*8 +: 8]), CW'(8'h3F));
        tick(); #1;
        chk("b2b_pulse_end", CW'(mb.respcyc), CW'(0));

        // gapped burst for 0x40 with reqcyc held high throughout
        mb.reqcyc = 1'b1; mb.addr = 64'h40;
        tick(); #1;
        chk("gap_req_addr", CW'(mb.bus_req), CW'(64'h40));
        mb.bus_reqack = 1'b1;
        tick(); mb.bus_reqack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                mb.bus_respcyc = 1'b0; #1;
                chk("gap_noack",   CW'(mb.bus_respack), CW'(0));
                chk("gap_respcyc", CW'(mb.respcyc),     CW'(0));
                tick(); tick();
            end
            mb.bus_respcyc = 1'b1; mb.bus_resp = beat_word(i, 1'b0); #1;
            chk("gap_ack", CW'(mb.bus_respack), CW'(1));
            if (i == 3) chk("gap_hold_data", CW'(mb.data), CW'(exp_line));
            tick();
        end
        mb.bus_respcyc = 1'b0; mb.addr = 64'h80; #1;
        chk("gap_respcyc_pulse", CW'(mb.respcyc), CW'(1));
        chk("gap_data",          CW'(mb.data),    CW'(exp_line));

        // DONE refuses the request; the following IDLE cycle takes it
        tick(); #1;
        chk("turn_idle_reqcyc", CW'(mb.bus_reqcyc), CW'(0));
        chk("turn_idle_resp",   CW'(mb.respcyc),    CW'(0));
        tick(); #1;
        chk("turn_req_valid", CW'(mb.bus_reqcyc), CW'(1));
        chk("turn_req_addr",  CW'(mb.bus_req),    CW'(64'h80));
        mb.bus_reqack = 1'b1;
        tick(); mb.bus_reqack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mb.bus_respcyc = 1'b1; mb.bus_resp = beat_word(i, 1'b1);
            tick();
        end

        // reset during beat 4 abandons the transfer
        mb.bus_resp = beat_word(4, 1'b1); reset = 1'b0;
        tick(); reset = 1'b1; mb.reqcyc = 1'b0; #1;
        chk("mid_rst_reqcyc",  CW'(mb.bus_reqcyc),  CW'(0));
        chk("mid_rst_respcyc", CW'(mb.respcyc),     CW'(0));
        chk("mid_rst_respack", CW'(mb.bus_respack), CW'(0));
        chk("mid_rst_data",    CW'(mb.data),        CW'(0));
        for (int i = 5; i < 9; i++) begin
            mb.bus_resp = beat_word(i, 1'b1); #1;
            chk("stale_noack", CW'(mb.bus_respack), CW'(0));
            tick(); #1;
            chk("stale_respcyc", CW'(mb.respcyc), CW'(0));
        end
        mb.bus_respcyc = 1'b0;

        // tag-filtered transfer with inverted data
        mb.reqcyc = 1'b1; mb.addr = 64'h2000_00C0;
        tick(); mb.reqcyc = 1'b0; #1;
        chk("tag_req_addr", CW'(mb.bus_req), CW'(64'h2000_00C0));
        mb.bus_reqack = 1'b1;
        tick(); mb.bus_reqack = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef MUSKBUS_READER_TAGCHK_EN
            if (i == 3) begin
                mb.bus_respcyc = 1'b1; mb.bus_resp = beat_word(20, 1'b0); mb.bus_resptag = '0; #1;
                chk("tag_bad_noack", CW'(mb.bus_respack), CW'(0));
                tick();
            end
            mb.bus_resptag = 13'h1100;
`else
            mb.bus_resptag = '0;
`endif
            mb.bus_respcyc = 1'b1; mb.bus_resp = beat_word(i, 1'b1); #1;
            chk("tag_beat_ack", CW'(mb.bus_respack), CW'(1));
            if (i == 4) chk("tag_mid_data", CW'(mb.data), CW'(0));
            tick();
        end
        mb.bus_respcyc = 1'b0; #1;
        chk("tag_respcyc", CW'(mb.respcyc), CW'(1));
        chk("tag_data",    CW'(mb.data),    CW'(inv_line));
        tick(); #1;
        chk("tag_pulse_end", CW'(mb.respcyc), CW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
